// File: rtl/riscv_pkg.sv
// Shared encodings for the pipeline control path: ResultSrc values, forward-select
// codes, the ID/EX control word and its bubble value.
package riscv_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
  } idex_ctrl_t;

  // A bubble must never write state or redirect the PC.
  localparam idex_ctrl_t IDEX_CTRL_BUBBLE = '{
    reg_write:  1'b0,
    result_src: RES_ALU,
    mem_write:  1'b0,
    jump:       1'b0,
    branch:     1'b0,
    alu_src:    1'b0
  };

  // Bit 0 of ResultSrc marks an instruction whose result comes from memory.
  function automatic logic result_from_mem(input logic [1:0] result_src);
    return result_src[0];
  endfunction

endpackage

// File: rtl/ctrl_pipeline_hazard_unit.sv
// Combinational hazard detection: stall, flush and forward selects.
// Build option FORWARD_EN: when defined, forwarding is built and only load-use
// hazards stall; otherwise forwards stay at the register file and every RAW
// dependence on EX or MEM stalls decode.
module hazard_unit
  import riscv_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs1_d,
  input  logic [RA_W-1:0] rs2_d,
  input  logic [RA_W-1:0] rs1_e,
  input  logic [RA_W-1:0] rs2_e,
  input  logic [RA_W-1:0] rd_e,
  input  logic [RA_W-1:0] rd_m,
  input  logic [RA_W-1:0] rd_w,
  input  logic            reg_write_e,
  input  logic            reg_write_m,
  input  logic            reg_write_w,
  input  logic [1:0]      result_src_e,
  input  logic            pcsrc_e,
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_d,
  output logic            flush_e,
  output logic [1:0]      forward_ae,
  output logic [1:0]      forward_be
);

  logic stall_s;
  logic unused_s;

  // x0 is hardwired, so a zero destination is never a dependence.
  function automatic logic src_hit(input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rd);
    return (rd != {RA_W{1'b0}}) && (rs == rd);
  endfunction

`ifdef FORWARD_EN
  // MEM is the younger producer, so it wins over WB.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs,
                                         input logic rw_m, input logic [RA_W-1:0] rdm,
                                         input logic rw_w, input logic [RA_W-1:0] rdw);
    logic [1:0] sel;
    if (rw_m && src_hit(rs, rdm)) begin
      sel = FWD_MEM;
    end else if (rw_w && src_hit(rs, rdw)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  // Only a load in EX cannot be covered by forwarding.
  always_comb begin
    stall_s    = result_from_mem(result_src_e) &
                 (src_hit(rs1_d, rd_e) | src_hit(rs2_d, rd_e));
    forward_ae = fwd_sel(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w);
    forward_be = fwd_sel(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w);
  end

  assign unused_s = reg_write_e;
`else
  // Without forwarding, any pending write in EX or MEM to a source stalls decode.
  always_comb begin
    stall_s    = (reg_write_e & (src_hit(rs1_d, rd_e) | src_hit(rs2_d, rd_e))) |
                 (reg_write_m & (src_hit(rs1_d, rd_m) | src_hit(rs2_d, rd_m)));
    forward_ae = FWD_RF;
    forward_be = FWD_RF;
  end

  assign unused_s = ^{rs1_e, rs2_e, rd_w, reg_write_w, result_src_e};
`endif

  // A taken branch/jump kills the D and E slots; a stall holds F/D and bubbles E.
  always_comb begin
    stall_f = stall_s;
    stall_d = stall_s;
    flush_d = pcsrc_e;
    flush_e = stall_s | pcsrc_e;
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// Control-side pipeline registers (ID/EX, EX/MEM, MEM/WB) for a 5-stage RISC-V
// core, with PCSrcE resolution and the hazard unit.
// Build option FORWARD_EN selects forwarding versus stall-on-RAW in hazard_unit.
module ctrl_pipeline
  import riscv_pkg::*;
#(
  parameter int RA_W   = 5,
  parameter int ALUC_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic              JumpD,
  input  logic              BranchD,
  input  logic              ALUSrcD,
  input  logic [1:0]        ResultSrcD,
  input  logic [ALUC_W-1:0] ALUControlD,
  input  logic [RA_W-1:0]   Rs1D,
  input  logic [RA_W-1:0]   Rs2D,
  input  logic [RA_W-1:0]   RdD,
  input  logic              ZeroE,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic              ALUSrcE,
  output logic [RA_W-1:0]   Rs1E,
  output logic [RA_W-1:0]   Rs2E,
  output logic [RA_W-1:0]   RdE,
  output logic              MemWriteM,
  output logic              RegWriteM,
  output logic [RA_W-1:0]   RdM,
  output logic [1:0]        ResultSrcW,
  output logic              RegWriteW,
  output logic [RA_W-1:0]   RdW,
  output logic              PCSrcE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE
);

  idex_ctrl_t        ctrl_e_q, ctrl_e_d;
  logic [ALUC_W-1:0] aluc_e_q, aluc_e_d;
  logic [RA_W-1:0]   rs1_e_q, rs1_e_d, rs2_e_q, rs2_e_d, rd_e_q, rd_e_d;
  logic              reg_write_m_q, reg_write_m_d, mem_write_m_q, mem_write_m_d;
  logic [1:0]        result_src_m_q, result_src_m_d;
  logic [RA_W-1:0]   rd_m_q, rd_m_d;
  logic              reg_write_w_q, reg_write_w_d;
  logic [1:0]        result_src_w_q, result_src_w_d;
  logic [RA_W-1:0]   rd_w_q, rd_w_d;

  // ID/EX next state: a flush inserts an all-zero bubble in place of the D slot.
  always_comb begin
    if (FlushE) begin
      ctrl_e_d = IDEX_CTRL_BUBBLE;
      aluc_e_d = {ALUC_W{1'b0}};
      rs1_e_d  = {RA_W{1'b0}};
      rs2_e_d  = {RA_W{1'b0}};
      rd_e_d   = {RA_W{1'b0}};
    end else begin
      ctrl_e_d = '{reg_write: RegWriteD, result_src: ResultSrcD, mem_write: MemWriteD,
                   jump: JumpD, branch: BranchD, alu_src: ALUSrcD};
      aluc_e_d = ALUControlD;
      rs1_e_d  = Rs1D;
      rs2_e_d  = Rs2D;
      rd_e_d   = RdD;
    end
  end

  // EX/MEM and MEM/WB always advance.
  always_comb begin
    reg_write_m_d  = ctrl_e_q.reg_write;
    mem_write_m_d  = ctrl_e_q.mem_write;
    result_src_m_d = ctrl_e_q.result_src;
    rd_m_d         = rd_e_q;
    reg_write_w_d  = reg_write_m_q;
    result_src_w_d = result_src_m_q;
    rd_w_d         = rd_m_q;
  end

  // Pipeline control registers; reset clears every stage immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_e_q       <= IDEX_CTRL_BUBBLE;
      aluc_e_q       <= {ALUC_W{1'b0}};
      rs1_e_q        <= {RA_W{1'b0}};
      rs2_e_q        <= {RA_W{1'b0}};
      rd_e_q         <= {RA_W{1'b0}};
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      result_src_m_q <= RES_ALU;
      rd_m_q         <= {RA_W{1'b0}};
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= RES_ALU;
      rd_w_q         <= {RA_W{1'b0}};
    end else begin
      ctrl_e_q       <= ctrl_e_d;
      aluc_e_q       <= aluc_e_d;
      rs1_e_q        <= rs1_e_d;
      rs2_e_q        <= rs2_e_d;
      rd_e_q         <= rd_e_d;
      reg_write_m_q  <= reg_write_m_d;
      mem_write_m_q  <= mem_write_m_d;
      result_src_m_q <= result_src_m_d;
      rd_m_q         <= rd_m_d;
      reg_write_w_q  <= reg_write_w_d;
      result_src_w_q <= result_src_w_d;
      rd_w_q         <= rd_w_d;
    end
  end

  // Branch/jump resolution in EX.
  always_comb begin
    PCSrcE = (ctrl_e_q.branch & ZeroE) | ctrl_e_q.jump;
  end

  assign ALUControlE = aluc_e_q;
  assign ALUSrcE     = ctrl_e_q.alu_src;
  assign Rs1E        = rs1_e_q;
  assign Rs2E        = rs2_e_q;
  assign RdE         = rd_e_q;
  assign MemWriteM   = mem_write_m_q;
  assign RegWriteM   = reg_write_m_q;
  assign RdM         = rd_m_q;
  assign ResultSrcW  = result_src_w_q;
  assign RegWriteW   = reg_write_w_q;
  assign RdW         = rd_w_q;

  hazard_unit #(.RA_W(RA_W)) u_hazard (
    .rs1_d        (Rs1D),
    .rs2_d        (Rs2D),
    .rs1_e        (rs1_e_q),
    .rs2_e        (rs2_e_q),
    .rd_e         (rd_e_q),
    .rd_m         (rd_m_q),
    .rd_w         (rd_w_q),
    .reg_write_e  (ctrl_e_q.reg_write),
    .reg_write_m  (reg_write_m_q),
    .reg_write_w  (reg_write_w_q),
    .result_src_e (ctrl_e_q.result_src),
    .pcsrc_e      (PCSrcE),
    .stall_f      (StallF),
    .stall_d      (StallD),
    .flush_d      (FlushD),
    .flush_e      (FlushE),
    .forward_ae   (ForwardAE),
    .forward_be   (ForwardBE)
  );

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: each vector drives the D-stage inputs after a
// rising edge and queues the hand-computed outputs; a monitor checks on the falling edge.
module tb_ctrl_pipeline;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  logic reset;
  logic RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ZeroE;
  logic [1:0] ResultSrcD;
  logic [2:0] ALUControlD;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic [2:0] ALUControlE;
  logic       ALUSrcE, MemWriteM, RegWriteM, RegWriteW, PCSrcE;
  logic [4:0] Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcW, ForwardAE, ForwardBE;
  logic       StallF, StallD, FlushD, FlushE;

  typedef struct packed {
    logic       rst, rw, mw, j, b, alus;
    logic [1:0] rs;
    logic [2:0] aluc;
    logic [4:0] rs1, rs2, rd;
    logic       zero;
  } din_t;

  typedef struct packed {
    logic [2:0] aluc_e;
    logic       alus_e;
    logic [4:0] rd_e;
    logic       mw_m, rw_m;
    logic [4:0] rd_m;
    logic [1:0] rs_w;
    logic       rw_w;
    logic [4:0] rd_w;
    logic       pc, stall_f, stall_d, flush_d, flush_e;
    logic [1:0] fa, fb;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_iss  = 0;

  ctrl_pipeline #(.RA_W(5), .ALUC_W(3)) dut (
    .clk(clk), .reset(reset),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .MemWriteM(MemWriteM), .RegWriteM(RegWriteM), .RdM(RdM),
    .ResultSrcW(ResultSrcW), .RegWriteW(RegWriteW), .RdW(RdW),
    .PCSrcE(PCSrcE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  function automatic din_t di(logic rst, logic rw, logic mw, logic j, logic b, logic alus,
                              logic [1:0] rs, logic [2:0] aluc,
                              logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic zero);
    return '{rst: rst, rw: rw, mw: mw, j: j, b: b, alus: alus, rs: rs, aluc: aluc,
             rs1: rs1, rs2: rs2, rd: rd, zero: zero};
  endfunction

  // Stall flags are expected equal on F and D, so one argument drives both.
  function automatic exp_t ex(logic [2:0] aluc_e, logic alus_e, logic [4:0] rd_e,
                              logic mw_m, logic rw_m, logic [4:0] rd_m,
                              logic [1:0] rs_w, logic rw_w, logic [4:0] rd_w,
                              logic pc, logic st, logic fd, logic fe,
                              logic [1:0] fa, logic [1:0] fb);
    return '{aluc_e: aluc_e, alus_e: alus_e, rd_e: rd_e, mw_m: mw_m, rw_m: rw_m, rd_m: rd_m,
             rs_w: rs_w, rw_w: rw_w, rd_w: rd_w, pc: pc, stall_f: st, stall_d: st,
             flush_d: fd, flush_e: fe, fa: fa, fb: fb};
  endfunction

  function automatic exp_t observed();
    return '{aluc_e: ALUControlE, alus_e: ALUSrcE, rd_e: RdE, mw_m: MemWriteM,
             rw_m: RegWriteM, rd_m: RdM, rs_w: ResultSrcW, rw_w: RegWriteW, rd_w: RdW,
             pc: PCSrcE, stall_f: StallF, stall_d: StallD, flush_d: FlushD,
             flush_e: FlushE, fa: ForwardAE, fb: ForwardBE};
  endfunction

  task automatic issue(input din_t d, input exp_t e);
    reset       = d.rst;
    RegWriteD   = d.rw;
    MemWriteD   = d.mw;
    JumpD       = d.j;
    BranchD     = d.b;
    ALUSrcD     = d.alus;
    ResultSrcD  = d.rs;
    ALUControlD = d.aluc;
    Rs1D        = d.rs1;
    Rs2D        = d.rs2;
    RdD         = d.rd;
    ZeroE       = d.zero;
    exp_q.push_back(e);
    n_iss++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop one expectation per cycle, compare on the falling edge.
  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = observed();
        n_vec++;
        if (a !== e) begin
          n_miss++;
          $display("FAIL vec%0d: got aluc_e=%0d alus_e=%b rd_e=%0d mw_m=%b rw_m=%b rd_m=%0d rs_w=%b rw_w=%b rd_w=%0d pc=%b st=%b%b fd=%b fe=%b fa=%b fb=%b required %h got %h",
                   n_vec, a.aluc_e, a.alus_e, a.rd_e, a.mw_m, a.rw_m, a.rd_m, a.rs_w, a.rw_w,
                   a.rd_w, a.pc, a.stall_f, a.stall_d, a.flush_d, a.flush_e, a.fa, a.fb, e, a);
        end
      end
    end
  end

  // Bound on total run time.
  initial begin : watchdog
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d of %0d vectors checked", n_vec, n_iss);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    din_t nop, d_use, d_ld_use;
    exp_t z;
    nop = di(L,L,L,L,L,L,2'b00,3'd0,5'd0,5'd0,5'd0,L);
    z   = ex(3'd0,L,5'd0, L,L,5'd0, 2'b00,L,5'd0, L,L,L,L, 2'b00,2'b00);

    reset = 1'b1;
    RegWriteD = 1'b0; MemWriteD = 1'b0; JumpD = 1'b0; BranchD = 1'b0; ALUSrcD = 1'b0;
    ResultSrcD = 2'b00; ALUControlD = 3'd0; Rs1D = 5'd0; Rs2D = 5'd0; RdD = 5'd0; ZeroE = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Writes to x0 never forward or stall.
    issue(di(L,H,L,L,L,L,2'b00,3'd4,5'd0,5'd0,5'd0,L), z);
    issue(di(L,H,L,L,L,L,2'b00,3'd5,5'd0,5'd0,5'd8,L), ex(3'd4,L,5'd0, L,L,5'd0, 2'b00,L,5'd0, L,L,L,L, 2'b00,2'b00));
    issue(nop, ex(3'd5,L,5'd8, L,H,5'd0, 2'b00,L,5'd0, L,L,L,L, 2'b00,2'b00));
    issue(nop, ex(3'd0,L,5'd0, L,H,5'd8, 2'b00,H,5'd0, L,L,L,L, 2'b00,2'b00));
    issue(nop, ex(3'd0,L,5'd0, L,L,5'd0, 2'b00,H,5'd8, L,L,L,L, 2'b00,2'b00));

    // add x5 followed by a use of x5.
    d_use = di(L,H,L,L,L,L,2'b00,3'd2,5'd5,5'd3,5'd7,L);
    issue(di(L,H,L,L,L,L,2'b00,3'd1,5'd1,5'd2,5'd5,L), z);
`ifdef FORWARD_EN
    issue(d_use, ex(3'd1,L,5'd5, L,L,5'd0, 2'b00,L,5'd0, L,L,L,L, 2'b00,2'b00));
    issue(di(L,L,L,L,L,L,2'b00,3'd3,5'd5,5'd0,5'd0,L),
          ex(3'd2,L,5'd7, L,H,5'd5, 2'b00,L,5'd0, L,L,L,L, 2'b10,2'b00));
    issue(nop, ex(3'd3,L,5'd0, L,H,5'd7, 2'b00,H,5'd5, L,L,L,L, 2'b01,2'b00));
    issue(nop, ex(3'd0,L,5'd0, L,L,5'd0, 2'b00,H,5'd7, L,L,L,L, 2'b00,2'b00));
`else
    issue(d_use, ex(3'd1,L,5'd5, L,L,5'd0, 2'b00,L,5'd0, L,H,L,H, 2'b00,2'b00));
    issue(d_use, ex(3'd0,L,5'd0, L,H,5'd5, 2'b00,L,5'd0, L,H,L,H, 2'b00,2'b00));
    issue(d_use, ex(3'd0,L,5'd0, L,L,5'd0, 2'b00,H,5'd5, L,L,L,L, 2'b00,2'b00));
    issue(nop, ex(3'd2,L,5'd7, L,L,5'd0, 2'b00,L,5'd0, L,L,L,L, 2'b00,2'b00));
    issue(nop, ex(3'd0,L,5'd0, L,H,5'd7, 2'b00,L,5'd0, L,L,L,L, 2'b00,2'b00));
    issue(nop, ex(3'd0,L,5'd0, L,L,5'd0, 2'b00,H,5'd7, L,L,L,L, 2'b00,2'b00));
`endif

    // lw x6 followed by a use of x6 through Rs2.
    d_ld_use = di(L,H,L,L,L,L,2'b00,3'd6,5'd2,5'd6,5'd9,L);
    issue(di(L,H,L,L,L,H,2'b01,3'd0,5'd1,5'd0,5'd6,L), z);
    issue(d_ld_use, ex(3'd0,H,5'd6, L,L,5'd0, 2'b00,L,5'd0, L,H,L,H, 2'b00,2'b00));
`ifdef FORWARD_EN
    issue(d_ld_use, ex(3'd0,L,5'd0, L,H,5'd6, 2'b00,L,5'd0, L,L,L,L, 2'b00,2'b00));
    issue(nop, ex(3'd6,L,5'd9, L,L,5'd0, 2'b01,H,5'd6, L,L,L,L, 2'b00,2'b01));
`else
    issue(d_ld_use, ex(3'd0,L,5'd0, L,H,5'd6, 2'b00,L,5'd0, L,H,L,H, 2'b00,2'b00));
    issue(d_ld_use, ex(3'd0,L,5'd0, L,L,5'd0, 2'b01,H,5'd6, L,L,L,L, 2'b00,2'b00));
    issue(nop, ex(3'd6,L,5'd9, L,L,5'd0, 2'b00,L,5'd0, L,L,L,L, 2'b00,2'b00));
`endif
    issue(nop, ex(3'd0,L,5'd0, L,H,5'd9, 2'b00,L,5'd0, L,L,L,L, 2'b00,2'b00));
    issue(nop, ex(3'd0,L,5'd0, L,L,5'd0, 2'b00,H,5'd9, L,L,L,L, 2'b00,2'b00));

    // Branch taken, branch not taken, then jump.
    issue(di(L,L,L,L,H,L,2'b00,3'd1,5'd3,5'd4,5'd0,L), z);
    issue(di(L,H,L,L,L,L,2'b00,3'd2,5'd0,5'd0,5'd10,H), ex(3'd1,L,5'd0, L,L,5'd0, 2'b00,L,5'd0, H,L,H,H, 2'b00,2'b00));
    issue(di(L,L,L,L,H,L,2'b00,3'd3,5'd3,5'd4,5'd0,H), z);
    issue(di(L,H,L,L,L,L,2'b00,3'd2,5'd0,5'd0,5'd10,L), ex(3'd3,L,5'd0, L,L,5'd0, 2'b00,L,5'd0, L,L,L,L, 2'b00,2'b00));
    issue(di(L,H,L,H,L,L,2'b10,3'd0,5'd0,5'd0,5'd1,L), ex(3'd2,L,5'd10, L,L,5'd0, 2'b00,L,5'd0, L,L,L,L, 2'b00,2'b00));
    issue(di(L,L,L,L,L,L,2'b00,3'd7,5'd0,5'd0,5'd0,L), ex(3'd0,L,5'd1, L,H,5'd10, 2'b00,L,5'd0, H,L,H,H, 2'b00,2'b00));
    issue(nop, ex(3'd0,L,5'd0, L,H,5'd1, 2'b00,H,5'd10, L,L,L,L, 2'b00,2'b00));
    issue(nop, ex(3'd0,L,5'd0, L,L,5'd0, 2'b10,H,5'd1, L,L,L,L, 2'b00,2'b00));

    // Store reaches MEM two edges after decode.
    issue(di(L,L,H,L,L,L,2'b00,3'd0,5'd2,5'd3,5'd0,L), z);
    issue(nop, z);
    issue(nop, ex(3'd0,L,5'd0, H,L,5'd0, 2'b00,L,5'd0, L,L,L,L, 2'b00,2'b00));
    issue(nop, z);

    // Load-use and jump forced together: both flushes hold.
    issue(di(L,H,L,H,L,L,2'b01,3'd0,5'd0,5'd0,5'd6,L), z);
    issue(di(L,L,L,L,L,L,2'b00,3'd1,5'd6,5'd0,5'd0,L), ex(3'd0,L,5'd6, L,L,5'd0, 2'b00,L,5'd0, H,H,H,H, 2'b00,2'b00));
    issue(nop, ex(3'd0,L,5'd0, L,H,5'd6, 2'b00,L,5'd0, L,L,L,L, 2'b00,2'b00));
    issue(nop, ex(3'd0,L,5'd0, L,L,5'd0, 2'b01,H,5'd6, L,L,L,L, 2'b00,2'b00));

    // Reset mid-stream with RegWriteD=1 applied, then release.
    issue(di(L,H,L,L,L,L,2'b00,3'd2,5'd0,5'd0,5'd5,L), z);
    issue(di(L,H,L,L,L,L,2'b00,3'd3,5'd0,5'd0,5'd6,L), ex(3'd2,L,5'd5, L,L,5'd0, 2'b00,L,5'd0, L,L,L,L, 2'b00,2'b00));
    issue(di(H,H,L,L,L,L,2'b00,3'd4,5'd0,5'd0,5'd7,L), z);
    issue(di(H,H,L,L,L,L,2'b00,3'd4,5'd0,5'd0,5'd7,L), z);
    issue(nop, z);
    issue(nop, z);
    issue(di(L,H,L,L,L,L,2'b00,3'd5,5'd0,5'd0,5'd9,L), z);
    issue(nop, ex(3'd5,L,5'd9, L,L,5'd0, 2'b00,L,5'd0, L,L,L,L, 2'b00,2'b00));
    issue(nop, ex(3'd0,L,5'd0, L,H,5'd9, 2'b00,L,5'd0, L,L,L,L, 2'b00,2'b00));

    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0 || n_vec != n_iss + 1) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left unchecked, %0d checked of %0d issued",
               exp_q.size(), n_vec - 1, n_iss);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
